div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Shares one iterative Divider (10-bit dividend, 5-bit divisor, 5-bit multiplexed quotient/remainder output) between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the divider's clear/start/serial-operand protocol, captures quotient, remainder and error flags, and returns one tagged response per request.
- Sits between client logic and the Divider instance; the Divider is driven only by this block.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DVD_W, 10, dividend width (equals Divider data_in width)
- DVS_W, 5, divisor/quotient/remainder width (equals Divider data_out width)
- TMO, 64, max cycles in WAIT before timeout abort
- ID_W, $clog2(NREQ) (local, min 1), requester id width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant/accept pulse
- req_dividend  in  NREQ*DVD_W  packed dividends, requester i at [i*DVD_W +: DVD_W]
- req_divisor  in  NREQ*DVS_W  packed divisors
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_quot  out  DVS_W  quotient
- rsp_rem  out  DVS_W  remainder
- rsp_divby0  out  1  divider reported divide-by-zero
- rsp_ov  out  1  divider reported quotient overflow
- rsp_tmo  out  1  timeout abort
- div_rst  out  1  Divider reset
- div_start  out  1  Divider start pulse
- div_data  out  DVD_W  Divider data_in
- div_out  in  DVS_W  Divider data_out
- div_doneq  in  1  quotient valid on div_out
- div_donew  in  1  remainder valid on div_out
- div_by0  in  1  Divider DivBy0
- div_ov  in  1  Divider OV

Behaviour:
- Reset values:
  - State IDLE; all outputs 0 except div_rst; rr pointer = NREQ-1, so requester 0 wins first.
  - div_rst = rst OR (state==CLR), combinational, so the Divider is cleared whenever rst is high.
- States: IDLE -> CLR -> START -> DVD -> DVS -> WAIT -> RSP -> IDLE.
- IDLE:
  - If any req_valid, pick the first valid index after the rr pointer (wrapping).
  - Pulse req_ready[winner] for that cycle; latch id, dividend and divisor; go to CLR.
  - The request is accepted on valid && ready in the same cycle; no grant occurs in any other state.
- CLR: div_rst=1 for 1 cycle; clear captured results and flags.
- START: div_start=1 for 1 cycle.
- DVD: div_data = latched dividend for 1 cycle.
- DVS: div_data = divisor zero-extended to DVD_W for 1 cycle; clear the timeout counter.
- div_data is 0 in all states other than DVD and DVS.
- WAIT:
  - div_doneq: capture div_out into quot and set seen_q.
  - div_donew: capture div_out into rem and set seen_r.
  - Both in the same cycle: both capture the same div_out.
  - Exit to RSP when seen_q && seen_r, including the update made this cycle.
  - div_by0 or div_ov high in any cycle: set the matching flag and go to RSP immediately. quot/rem then hold whatever was captured, else 0.
  - Counter reaches TMO-1 with no exit: set rsp_tmo and go to RSP.
  - Precedence for exits in the same cycle: error > done > timeout. All flags raised that cycle are reported.
- RSP:
  - rsp_valid=1; rsp_id/quot/rem/flags stable and registered.
  - On rsp_ready: rr pointer := served id, go to IDLE.
  - Minimum turnaround: 1 idle cycle between response accept and the next grant.
- Latency from grant to earliest rsp_valid: 5 cycles + divider compute time.
- Reset mid-operation: return to IDLE at once, drop rsp_valid, no response for the in-flight request.
- Requester deasserting req_valid before a grant: no effect. Operands are sampled only at grant.

Decomposition:
- div_sched_pkg:
  - state enum (IDLE, CLR, START, DVD, DVS, WAIT, RSP)
  - DVD_W/DVS_W defaults
  - TMO default
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant plus index.
  - Purely combinational, instantiated once.

Test Plan:
- Req0 75/11, rsp_ready=1 -> single req_ready[0] pulse; div_rst, div_start, data 75, data 11 on consecutive cycles; rsp id=0 quot=6 rem=9, all flags 0.
- Req0 80/9 and req1 150/13 asserted together and held -> req0 served first (8,8), then req1 (11,7); then a new req0+req1 pair grants req1 first.
- Req1 140/0 -> rsp_divby0=1, id=1, no hang.
- Req0 226/5 -> rsp_ov=1 (quotient 45 > 31).
- Divider model never asserts done -> rsp_tmo=1 exactly TMO cycles after DVS.
- rst pulsed during WAIT of 100/8 -> outputs to reset values, no response; a subsequent 100/8 returns (12,4).

Source files
------------

// File: rtl/div_sched_pkg.sv
// -----------------------------------------------------------------------------
// div_sched_pkg
// Shared types and defaults for the divider scheduler.
//   state_t   : scheduler sequencing states
//   DVD_W_DEF : default dividend width (Divider data_in)
//   DVS_W_DEF : default divisor/quotient/remainder width (Divider data_out)
//   TMO_DEF   : default WAIT-state timeout in cycles
//   id_width  : requester id width, never less than 1 bit
// -----------------------------------------------------------------------------
package div_sched_pkg;

    localparam int DVD_W_DEF = 10;
    localparam int DVS_W_DEF = 5;
    localparam int TMO_DEF   = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_DVD   = 3'd3,
        ST_DVS   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_RSP   = 3'd6
    } state_t;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_sched_if.sv
// -----------------------------------------------------------------------------
// div_sched_if
// Client-side request/response bus of the divider scheduler.
//   master : client logic (drives requests, accepts responses)
//   slave  : div_sched (grants requests, presents responses)
// Signals: req_valid/req_ready (per requester), packed operands,
//          rsp_valid/rsp_ready handshake, tagged result and status flags.
// -----------------------------------------------------------------------------
interface div_sched_if #(
    parameter int NREQ  = 2,
    parameter int DVD_W = 10,
    parameter int DVS_W = 5
);
    import div_sched_pkg::*;

    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DVD_W-1:0] req_dividend;
    logic [NREQ*DVS_W-1:0] req_divisor;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [DVS_W-1:0]      rsp_quot;
    logic [DVS_W-1:0]      rsp_rem;
    logic                  rsp_divby0;
    logic                  rsp_ov;
    logic                  rsp_tmo;

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem,
               rsp_divby0, rsp_ov, rsp_tmo
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem,
               rsp_divby0, rsp_ov, rsp_tmo
    );

endinterface

// File: rtl/div_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first requester strictly after
// the pointer, wrapping around, so the last-served requester has lowest
// priority.
//   i_req : request vector
//   i_ptr : index of the most recently served requester
//   i_en  : grant enable; no grant when low
//   o_gnt : one-hot grant
//   o_idx : index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx
);

    logic            w_found;
    logic [ID_W-1:0] w_pos;

    // Scan from ptr+1 around to ptr itself and take the first asserted request.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = ID_W'((int'(i_ptr) + k) % NREQ);
            if (i_en && !w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Shares one iterative Divider between NREQ requesters. Grants round-robin,
// latches the winner's operands, runs the Divider clear/start/dividend/divisor
// sequence, collects quotient, remainder and error flags, and returns one
// tagged response per accepted request.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : client request/response bus (slave side)
//   div_rst      : Divider reset (high during rst and the CLR state)
//   div_start    : Divider start pulse
//   div_data     : Divider data_in (dividend, then zero-extended divisor)
//   div_out      : Divider data_out (quotient or remainder)
//   div_doneq/w  : quotient / remainder valid on div_out
//   div_by0/ov   : Divider divide-by-zero / quotient overflow
// -----------------------------------------------------------------------------
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    div_sched_if.slave       bus,
    output logic             div_rst,
    output logic             div_start,
    output logic [DVD_W-1:0] div_data,
    input  logic [DVS_W-1:0] div_out,
    input  logic             div_doneq,
    input  logic             div_donew,
    input  logic             div_by0,
    input  logic             div_ov
);

    localparam int ID_W  = id_width(NREQ);
    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic             r_seen_q;
    logic             r_seen_r;
    logic             r_by0;
    logic             r_ov;
    logic             r_tmo;
    logic             r_rsp_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [NREQ-1:0]  w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [DVD_W-1:0] w_sel_dvd;
    logic [DVS_W-1:0] w_sel_dvs;
    logic             w_seen_q;
    logic             w_seen_r;
    logic             w_err;
    logic             w_done;
    logic             w_tmo;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .i_en  (r_state == ST_IDLE),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    // The grant pulse is the accept strobe, so it must be combinational.
    assign bus.req_ready = w_gnt;

    // Divider is held in reset whenever the scheduler itself is in reset.
    assign div_rst   = rst | (r_state == ST_CLR);
    assign div_start = (r_state == ST_START);

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_quot   = r_quot;
    assign bus.rsp_rem    = r_rem;
    assign bus.rsp_divby0 = r_by0;
    assign bus.rsp_ov     = r_ov;
    assign bus.rsp_tmo    = r_tmo;

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_dvd = '0;
        w_sel_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_dvd = bus.req_dividend[i*DVD_W +: DVD_W];
                w_sel_dvs = bus.req_divisor[i*DVS_W +: DVS_W];
            end else begin
                w_sel_dvd = w_sel_dvd;
                w_sel_dvs = w_sel_dvs;
            end
        end
    end

    // Serial operand feed: dividend, then divisor, zero elsewhere.
    always_comb begin
        case (r_state)
            ST_DVD:  div_data = r_dvd;
            ST_DVS:  div_data = {{(DVD_W-DVS_W){1'b0}}, r_dvs};
            default: div_data = '0;
        endcase
    end

    // WAIT exit terms include the capture made in the current cycle.
    always_comb begin
        w_seen_q = r_seen_q | div_doneq;
        w_seen_r = r_seen_r | div_donew;
        w_err    = div_by0 | div_ov;
        w_done   = w_seen_q & w_seen_r;
        w_tmo    = (r_cnt == CNT_W'(TMO - 1));
    end

    // Sequencer with registered results and response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ID_W'(NREQ - 1);
            r_id        <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_seen_q    <= 1'b0;
            r_seen_r    <= 1'b0;
            r_by0       <= 1'b0;
            r_ov        <= 1'b0;
            r_tmo       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_id    <= w_gnt_idx;
                        r_dvd   <= w_sel_dvd;
                        r_dvs   <= w_sel_dvs;
                        r_state <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    r_quot   <= '0;
                    r_rem    <= '0;
                    r_seen_q <= 1'b0;
                    r_seen_r <= 1'b0;
                    r_by0    <= 1'b0;
                    r_ov     <= 1'b0;
                    r_tmo    <= 1'b0;
                    r_state  <= ST_START;
                end
                ST_START: r_state <= ST_DVD;
                ST_DVD:   r_state <= ST_DVS;
                ST_DVS: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_doneq) r_quot <= div_out;
                    if (div_donew) r_rem  <= div_out;
                    r_seen_q <= w_seen_q;
                    r_seen_r <= w_seen_r;
                    r_by0    <= r_by0 | div_by0;
                    r_ov     <= r_ov | div_ov;
                    // Errors and completion beat the timeout.
                    if (w_err || w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end else if (w_tmo) begin
                        r_tmo       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        r_ptr       <= r_id;
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched
// Directed bench for div_sched with a behavioural iterative Divider model.
// Expected responses are queued at grant time and popped when the response
// handshake completes.
// -----------------------------------------------------------------------------
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int NREQ  = 2;
    localparam int DVD_W = 10;
    localparam int DVS_W = 5;
    localparam int TMO   = 64;

    typedef struct {
        int id;
        int quot;
        int rem;
        int by0;
        int ov;
        int tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_sched_if #(.NREQ(NREQ), .DVD_W(DVD_W), .DVS_W(DVS_W)) bus ();

    logic             div_rst;
    logic             div_start;
    logic [DVD_W-1:0] div_data;
    logic [DVS_W-1:0] div_out;
    logic             div_doneq;
    logic             div_donew;
    logic             div_by0;
    logic             div_ov;

    div_sched #(.NREQ(NREQ), .DVD_W(DVD_W), .DVS_W(DVS_W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .div_rst   (div_rst),
        .div_start (div_start),
        .div_data  (div_data),
        .div_out   (div_out),
        .div_doneq (div_doneq),
        .div_donew (div_donew),
        .div_by0   (div_by0),
        .div_ov    (div_ov)
    );

    // Behavioural Divider: start, dividend, divisor, a few compute cycles,
    // then quotient and remainder on consecutive cycles (or an error flag).
    logic [2:0]       m_ph;
    logic [2:0]       m_cnt;
    logic [DVD_W-1:0] m_dvd;
    logic [DVS_W-1:0] m_dvs;
    logic             m_hang;

    always @(posedge clk) begin
        if (div_rst) begin
            m_ph      <= 3'd0;
            m_cnt     <= 3'd0;
            m_dvd     <= '0;
            m_dvs     <= '0;
            div_out   <= '0;
            div_doneq <= 1'b0;
            div_donew <= 1'b0;
            div_by0   <= 1'b0;
            div_ov    <= 1'b0;
        end else begin
            div_doneq <= 1'b0;
            div_donew <= 1'b0;
            case (m_ph)
                3'd0: if (div_start) m_ph <= 3'd1;
                3'd1: begin m_dvd <= div_data; m_ph <= 3'd2; end
                3'd2: begin m_dvs <= div_data[DVS_W-1:0]; m_cnt <= 3'd3; m_ph <= 3'd3; end
                3'd3: begin
                    if (!m_hang) begin
                        if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
                        else if (m_dvs == '0) begin div_by0 <= 1'b1; m_ph <= 3'd6; end
                        else if ((m_dvd / DVD_W'(m_dvs)) > DVD_W'(31)) begin div_ov <= 1'b1; m_ph <= 3'd6; end
                        else begin
                            div_doneq <= 1'b1;
                            div_out   <= DVS_W'(m_dvd / DVD_W'(m_dvs));
                            m_ph      <= 3'd4;
                        end
                    end
                end
                3'd4: begin
                    div_donew <= 1'b1;
                    div_out   <= DVS_W'(m_dvd % DVD_W'(m_dvs));
                    m_ph      <= 3'd5;
                end
                default: m_ph <= m_ph;
            endcase
        end
    end

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise req_valid for idx, wait for its grant, queue the expected result.
    task automatic grant(input int idx, input logic [DVD_W-1:0] dvd, input logic [DVS_W-1:0] dvs);
        exp_t e;
        int   q;
        bus.req_dividend[idx*DVD_W +: DVD_W] = dvd;
        bus.req_divisor[idx*DVS_W +: DVS_W]  = dvs;
        bus.req_valid[idx] = 1'b1;
        #1;
        for (int n = 0; n < 40 && bus.req_ready == '0; n++) begin
            @(negedge clk);
            #1;
        end
        check("grant_onehot", 32'(bus.req_ready), 32'(1 << idx));
        e = '{id: idx, quot: 0, rem: 0, by0: 0, ov: 0, tmo: 0};
        if (m_hang) e.tmo = 1;
        else if (dvs == '0) e.by0 = 1;
        else begin
            q = int'(dvd) / int'(dvs);
            if (q > 31) e.ov = 1;
            else begin
                e.quot = q;
                e.rem  = int'(dvd) % int'(dvs);
            end
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        #1;
    endtask

    // Wait (bounded) for a response, compare against the queue head, accept it.
    task automatic wait_rsp();
        exp_t e;
        int   n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_id",     32'(bus.rsp_id),     32'(e.id));
            check("rsp_quot",   32'(bus.rsp_quot),   32'(e.quot));
            check("rsp_rem",    32'(bus.rsp_rem),    32'(e.rem));
            check("rsp_divby0", 32'(bus.rsp_divby0), 32'(e.by0));
            check("rsp_ov",     32'(bus.rsp_ov),     32'(e.ov));
            check("rsp_tmo",    32'(bus.rsp_tmo),    32'(e.tmo));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        m_hang           = 1'b0;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        check("rst_div_rst",   32'(div_rst),       32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_div_start", 32'(div_start),     32'd0);
        check("rst_div_data",  32'(div_data),      32'd0);
        rst = 1'b0;
        #1;
        check("idle_div_rst",  32'(div_rst),       32'd0);
        check("idle_ready",    32'(bus.req_ready), 32'd0);
        @(negedge clk);

        // Single request 75/11 with divider protocol trace
        grant(0, 10'd75, 5'd11);
        check("clr_div_rst",   32'(div_rst),       32'd1);
        check("clr_ready",     32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        check("start_pulse",   32'(div_start),     32'd1);
        check("start_div_rst", 32'(div_rst),       32'd0);
        @(negedge clk); #1;
        check("data_dividend", 32'(div_data),      32'd75);
        check("dvd_start_low", 32'(div_start),     32'd0);
        @(negedge clk); #1;
        check("data_divisor",  32'(div_data),      32'd11);
        wait_rsp();

        // Divide by zero from requester 1
        grant(1, 10'd140, 5'd0);
        wait_rsp();

        // Held pair: pointer sits on 1, so requester 0 goes first
        bus.req_dividend = {10'd150, 10'd80};
        bus.req_divisor  = {5'd13, 5'd9};
        bus.req_valid    = 2'b11;
        grant(0, 10'd80, 5'd9);
        check("pair_hold_req1", 32'(bus.req_valid), 32'd2);
        wait_rsp();
        grant(1, 10'd150, 5'd13);
        wait_rsp();

        // Quotient overflow 226/5 = 45
        grant(0, 10'd226, 5'd5);
        wait_rsp();

        // New pair after serving 0: requester 1 goes first
        bus.req_dividend = {10'd200, 10'd50};
        bus.req_divisor  = {5'd9, 5'd7};
        bus.req_valid    = 2'b11;
        grant(1, 10'd200, 5'd9);
        wait_rsp();
        grant(0, 10'd50, 5'd7);
        wait_rsp();

        // Timeout: divider never reports done
        m_hang = 1'b1;
        grant(0, 10'd100, 5'd3);
        repeat (3) @(negedge clk);
        #1;
        check("tmo_dvs_cycle", 32'(div_data), 32'd3);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TMO + 1));
        wait_rsp();
        m_hang = 1'b0;

        // Reset in WAIT: no response for the in-flight request
        grant(0, 10'd100, 5'd8);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_div_rst",   32'(div_rst),       32'd1);
        check("midrst_div_data",  32'(div_data),      32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        grant(0, 10'd100, 5'd8);
        wait_rsp();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
